// File: rtl/sram10t_arbiter_if.sv
// sram10t_arbiter_if
//   Requester-side bus of the sram10t_arbiter. Bundles the request
//   (valid/ready handshake plus payload) and response (one-cycle strobe
//   plus read bit) channels of both requesters A and B.
//   Ports per requester x in {a, b}:
//     x_req_valid  requester has a request
//     x_req_we     1 = write, 0 = read
//     x_req_addr   word address (ADDR_W bits)
//     x_req_wdata  write bit
//     x_req_ready  request accepted this cycle (driven by the arbiter)
//     x_rsp_valid  one-cycle completion strobe (driven by the arbiter)
//     x_rsp_rdata  read data, qualified by x_rsp_valid for reads
//   Modports: master = requester side, slave = arbiter side.
interface sram10t_arbiter_if #(
  parameter int ADDR_W = 4
);
  logic              a_req_valid;
  logic              a_req_we;
  logic [ADDR_W-1:0] a_req_addr;
  logic              a_req_wdata;
  logic              a_req_ready;
  logic              a_rsp_valid;
  logic              a_rsp_rdata;

  logic              b_req_valid;
  logic              b_req_we;
  logic [ADDR_W-1:0] b_req_addr;
  logic              b_req_wdata;
  logic              b_req_ready;
  logic              b_rsp_valid;
  logic              b_rsp_rdata;

  modport master (
    output a_req_valid, a_req_we, a_req_addr, a_req_wdata,
    input  a_req_ready, a_rsp_valid, a_rsp_rdata,
    output b_req_valid, b_req_we, b_req_addr, b_req_wdata,
    input  b_req_ready, b_rsp_valid, b_rsp_rdata
  );

  modport slave (
    input  a_req_valid, a_req_we, a_req_addr, a_req_wdata,
    output a_req_ready, a_rsp_valid, a_rsp_rdata,
    input  b_req_valid, b_req_we, b_req_addr, b_req_wdata,
    output b_req_ready, b_rsp_valid, b_rsp_rdata
  );
endinterface

// File: rtl/sram10t_arbiter.sv
// sram10t_arbiter
//   Two-requester arbiter and access sequencer for one dual-read 16x1
//   SRAM10T_16B macro. Every operation runs IDLE -> SETUP -> ACCESS and
//   the macro enable is low only in ACCESS, with all address/data/RdWr
//   pins frozen around that cycle so the macro never sees a pin move
//   while enabled. Two simultaneous reads may be merged into one
//   dual-read access (A on port 1, B on port 2).
//   Ports:
//     clk, rst_n     clock (shared with the macro), synchronous active-low reset
//     req            requester bus (slave modport), see sram10t_arbiter_if
//     sram_addr1     macro addr1 (write / read port 1)
//     sram_addr2     macro addr2 (read port 2)
//     sram_wdata     macro writeLine
//     sram_rdwr      macro RdWr, 1 = write
//     sram_dev_en_n  macro DevEn, active low
//     sram_rdata1/2  macro readLine1 / readLine2
//     busy           high whenever the sequencer is not in IDLE
module sram10t_arbiter #(
  parameter int ADDR_W     = 4,
  parameter bit PAIR_READS = 1'b1,
  parameter bit RR_INIT    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  sram10t_arbiter_if.slave  req,
  output logic [ADDR_W-1:0] sram_addr1,
  output logic [ADDR_W-1:0] sram_addr2,
  output logic              sram_wdata,
  output logic              sram_rdwr,
  output logic              sram_dev_en_n,
  input  logic              sram_rdata1,
  input  logic              sram_rdata2,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state;
  logic              rrPtr;      // 0 = A wins the next conflict, 1 = B
  logic              opA;        // in-flight op belongs to A
  logic              opB;        // in-flight op belongs to B
  logic              opWe;       // in-flight op is a write
  logic              aRspValid;
  logic              aRspRdata;
  logic              bRspValid;
  logic              bRspRdata;

  logic              grantA;
  logic              grantB;
  logic              togglePtr;
  logic              pairOk;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic              selWdata;

  // Two reads may share one dual-read access only when pairing is enabled.
  assign pairOk = PAIR_READS && !req.a_req_we && !req.b_req_we;

  // Grant decision: combinational, only meaningful in IDLE.
  always_comb begin
    grantA    = 1'b0;
    grantB    = 1'b0;
    togglePtr = 1'b0;
    if (state == IDLE) begin
      if (req.a_req_valid && req.b_req_valid) begin
        if (pairOk) begin
          grantA = 1'b1;
          grantB = 1'b1;
        end else begin
          // Conflict: the pointer decides and then moves to the other side.
          togglePtr = 1'b1;
          if (rrPtr) begin
            grantB = 1'b1;
          end else begin
            grantA = 1'b1;
          end
        end
      end else if (req.a_req_valid) begin
        grantA = 1'b1;
      end else if (req.b_req_valid) begin
        grantB = 1'b1;
      end else begin
        grantA = 1'b0;
        grantB = 1'b0;
      end
    end else begin
      grantA = 1'b0;
      grantB = 1'b0;
    end
  end

  // Payload of a lone granted op (A has precedence only when A is granted).
  always_comb begin
    selWe    = 1'b0;
    selAddr  = '0;
    selWdata = 1'b0;
    if (grantA) begin
      selWe    = req.a_req_we;
      selAddr  = req.a_req_addr;
      selWdata = req.a_req_wdata;
    end else begin
      selWe    = req.b_req_we;
      selAddr  = req.b_req_addr;
      selWdata = req.b_req_wdata;
    end
  end

  assign req.a_req_ready = grantA;
  assign req.b_req_ready = grantB;
  assign req.a_rsp_valid = aRspValid;
  assign req.a_rsp_rdata = aRspRdata;
  assign req.b_rsp_valid = bRspValid;
  assign req.b_rsp_rdata = bRspRdata;

  // Sequencer FSM: owns every macro pin, the pointer and the responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rrPtr         <= RR_INIT;
      opA           <= 1'b0;
      opB           <= 1'b0;
      opWe          <= 1'b0;
      sram_addr1    <= '0;
      sram_addr2    <= '0;
      sram_wdata    <= 1'b0;
      sram_rdwr     <= 1'b0;
      sram_dev_en_n <= 1'b1;
      busy          <= 1'b0;
      aRspValid     <= 1'b0;
      aRspRdata     <= 1'b0;
      bRspValid     <= 1'b0;
      bRspRdata     <= 1'b0;
    end else begin
      // Response strobes last exactly one cycle.
      aRspValid <= 1'b0;
      bRspValid <= 1'b0;
      case (state)
        IDLE: begin
          sram_dev_en_n <= 1'b1;
          if (grantA || grantB) begin
            // Pins may only move here: enable is high on both sides of this edge.
            state <= SETUP;
            busy  <= 1'b1;
            opA   <= grantA;
            opB   <= grantB;
            if (grantA && grantB) begin
              opWe       <= 1'b0;
              sram_addr1 <= req.a_req_addr;
              sram_addr2 <= req.b_req_addr;
              sram_rdwr  <= 1'b0;
              sram_wdata <= 1'b0;
            end else begin
              opWe       <= selWe;
              sram_addr1 <= selAddr;
              sram_addr2 <= selAddr;
              sram_rdwr  <= selWe;
              sram_wdata <= selWe & selWdata;
            end
            if (togglePtr) begin
              rrPtr <= ~rrPtr;
            end else begin
              rrPtr <= rrPtr;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SETUP: begin
          // Macro latches the address at this edge; enable it for one cycle.
          state         <= ACCESS;
          sram_dev_en_n <= 1'b0;
        end
        ACCESS: begin
          state         <= IDLE;
          sram_dev_en_n <= 1'b1;
          busy          <= 1'b0;
          aRspValid     <= opA;
          bRspValid     <= opB;
          // A always reads port 1; B reads port 2 only when paired with A.
          if (opA && !opWe) begin
            aRspRdata <= sram_rdata1;
          end else begin
            aRspRdata <= aRspRdata;
          end
          if (opB && !opWe) begin
            bRspRdata <= opA ? sram_rdata2 : sram_rdata1;
          end else begin
            bRspRdata <= bRspRdata;
          end
        end
        default: begin
          state         <= IDLE;
          sram_dev_en_n <= 1'b1;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram10t_arbiter.sv
// tb_sram10t_arbiter
//   Table-driven bench for sram10t_arbiter. Instance 1 uses PAIR_READS=1,
//   RR_INIT=0; instance 2 uses PAIR_READS=0, RR_INIT=1. Each instance has
//   a small behavioural model of the 16x1 dual-read macro.
module tb_sram10t_arbiter;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram10t_arbiter_if #(.ADDR_W(AW)) bus1 ();
  sram10t_arbiter_if #(.ADDR_W(AW)) bus2 ();

  logic [AW-1:0] s1Addr1, s1Addr2, s2Addr1, s2Addr2;
  logic s1Wdata, s1Rdwr, s1DevEnN, s1Rd1, s1Rd2, s1Busy;
  logic s2Wdata, s2Rdwr, s2DevEnN, s2Rd1, s2Rd2, s2Busy;

  sram10t_arbiter #(.ADDR_W(AW), .PAIR_READS(1'b1), .RR_INIT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(bus1),
    .sram_addr1(s1Addr1), .sram_addr2(s1Addr2), .sram_wdata(s1Wdata),
    .sram_rdwr(s1Rdwr), .sram_dev_en_n(s1DevEnN),
    .sram_rdata1(s1Rd1), .sram_rdata2(s1Rd2), .busy(s1Busy)
  );

  sram10t_arbiter #(.ADDR_W(AW), .PAIR_READS(1'b0), .RR_INIT(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(bus2),
    .sram_addr1(s2Addr1), .sram_addr2(s2Addr2), .sram_wdata(s2Wdata),
    .sram_rdwr(s2Rdwr), .sram_dev_en_n(s2DevEnN),
    .sram_rdata1(s2Rd1), .sram_rdata2(s2Rd2), .busy(s2Busy)
  );

  // Macro models: write at a clock edge while enabled with RdWr=1.
  logic [15:0] mem1 = 16'h0000;
  logic [15:0] mem2 = 16'h0000;
  assign s1Rd1 = mem1[s1Addr1];
  assign s1Rd2 = mem1[s1Addr2];
  assign s2Rd1 = mem2[s2Addr1];
  assign s2Rd2 = mem2[s2Addr2];
  always @(posedge clk) begin
    if (!s1DevEnN && s1Rdwr) mem1[s1Addr1] <= s1Wdata;
    if (!s2DevEnN && s2Rdwr) mem2[s2Addr1] <= s2Wdata;
  end

  typedef struct {
    logic       aV;  logic aWe; logic [3:0] aAddr; logic aWd;
    logic       bV;  logic bWe; logic [3:0] bAddr; logic bWd;
    logic       eARdy; logic eBRdy;
    logic [3:0] eAddr1; logic [3:0] eAddr2;
    logic       eRdwr; logic eWd;
    logic       eARsp; logic eBRsp; logic eARd; logic eBRd;
  } vec_t;

  vec_t vecs [12];
  int checks = 0;
  int failures = 0;

  // Pin history of instance 1, one entry per cycle (sampled at negedge).
  logic [9:0] h1, h2;
  logic d1, d2, rt1;
  int histN = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  // Advance to the next negedge and check the pin-stability rule around
  // the enabled cycle (skipping transitions caused by reset).
  task automatic step();
    logic [9:0] cur;
    logic curD, rtNow;
    @(negedge clk);
    cur   = {s1Addr1, s1Addr2, s1Wdata, s1Rdwr};
    curD  = s1DevEnN;
    rtNow = rst_n;
    if (histN >= 2 && !d1) begin
      if (rt1 && rtNow) chk("pinHold", histN, {h2, h1}, {h1, cur});
      chk("devEnPulse", histN, {d2, curD}, 2'b11);
    end
    h2 = h1; h1 = cur; d2 = d1; d1 = curD; rt1 = rtNow;
    histN++;
  endtask

  task automatic runVec(input vec_t v, input int idx);
    bus1.a_req_valid = v.aV; bus1.a_req_we = v.aWe; bus1.a_req_addr = v.aAddr; bus1.a_req_wdata = v.aWd;
    bus1.b_req_valid = v.bV; bus1.b_req_we = v.bWe; bus1.b_req_addr = v.bAddr; bus1.b_req_wdata = v.bWd;
    #1;
    chk("aReady", idx, bus1.a_req_ready, v.eARdy);
    chk("bReady", idx, bus1.b_req_ready, v.eBRdy);
    step();
    bus1.a_req_valid = 1'b0; bus1.b_req_valid = 1'b0;
    chk("addr1", idx, s1Addr1, v.eAddr1);
    chk("addr2", idx, s1Addr2, v.eAddr2);
    chk("rdwr", idx, s1Rdwr, v.eRdwr);
    chk("wdata", idx, s1Wdata, v.eWd);
    chk("setupEn", idx, {s1DevEnN, s1Busy}, 2'b11);
    step();
    chk("accessEn", idx, s1DevEnN, 1'b0);
    step();
    chk("rspValid", idx, {bus1.a_rsp_valid, bus1.b_rsp_valid}, {v.eARsp, v.eBRsp});
    chk("aRdata", idx, bus1.a_rsp_rdata, v.eARd);
    chk("bRdata", idx, bus1.b_rsp_rdata, v.eBRd);
    chk("idleEn", idx, {s1DevEnN, s1Busy}, 2'b10);
  endtask

  initial begin
    //            aV    aWe   aAddr aWd   bV    bWe   bAddr  bWd   aRdy bRdy  addr1  addr2  rdwr  wd    aRsp  bRsp  aRd   bRd
    vecs[0]  = '{1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd3,  4'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 4'd12, 4'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd5,  4'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd5,  4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd12, 1'b0, 1'b1, 1'b1, 4'd3,  4'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd9,  1'b1, 1'b0, 1'b1, 4'd9,  4'd9,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd9,  1'b0, 1'b0, 1'b1, 4'd9,  4'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 4'd12,1'b0, 1'b1, 1'b0, 4'd3,  1'b0, 1'b1, 1'b1, 4'd12, 4'd3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd5,  4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd5,  1'b0, 1'b0, 1'b1, 4'd5,  4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd3,  4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, 4'd5,  1'b0, 1'b1, 1'b1, 4'd9,  4'd5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    bus1.a_req_valid = 1'b0; bus1.a_req_we = 1'b0; bus1.a_req_addr = 4'd0; bus1.a_req_wdata = 1'b0;
    bus1.b_req_valid = 1'b0; bus1.b_req_we = 1'b0; bus1.b_req_addr = 4'd0; bus1.b_req_wdata = 1'b0;
    bus2.a_req_valid = 1'b0; bus2.a_req_we = 1'b0; bus2.a_req_addr = 4'd0; bus2.a_req_wdata = 1'b0;
    bus2.b_req_valid = 1'b0; bus2.b_req_we = 1'b0; bus2.b_req_addr = 4'd0; bus2.b_req_wdata = 1'b0;
    h1 = 10'd0; h2 = 10'd0; d1 = 1'b1; d2 = 1'b1; rt1 = 1'b0;
    step(); step();

    // Reset state of both instances.
    chk("rstPins1", 0, {s1DevEnN, s1Rdwr, s1Busy, s1Addr1, s1Addr2, s1Wdata}, {3'b100, 4'd0, 4'd0, 1'b0});
    chk("rstRsp1", 0, {bus1.a_rsp_valid, bus1.b_rsp_valid, bus1.a_rsp_rdata, bus1.b_rsp_rdata}, 4'b0000);
    chk("rstPins2", 0, {s2DevEnN, s2Rdwr, s2Busy}, 3'b100);
    rst_n = 1'b1;
    step();

    // Instance 2 (no pairing, B first): preload addr3=1, then A r3 / B r12.
    bus2.a_req_valid = 1'b1; bus2.a_req_we = 1'b1; bus2.a_req_addr = 4'd3; bus2.a_req_wdata = 1'b1;
    #1 chk("i2PreRdy", 0, bus2.a_req_ready, 1'b1);
    step(); bus2.a_req_valid = 1'b0; step(); step();
    chk("i2PreRsp", 0, bus2.a_rsp_valid, 1'b1);
    bus2.a_req_valid = 1'b1; bus2.a_req_we = 1'b0; bus2.a_req_addr = 4'd3; bus2.a_req_wdata = 1'b0;
    bus2.b_req_valid = 1'b1; bus2.b_req_we = 1'b0; bus2.b_req_addr = 4'd12; bus2.b_req_wdata = 1'b0;
    #1 chk("i2Rdy1", 0, {bus2.a_req_ready, bus2.b_req_ready}, 2'b01);
    step(); bus2.b_req_valid = 1'b0;
    chk("i2Addr1", 0, {s2Addr1, s2Addr2}, {4'd12, 4'd12});
    step(); step();
    chk("i2RspB", 0, {bus2.a_rsp_valid, bus2.b_rsp_valid, bus2.b_rsp_rdata}, 3'b010);
    chk("i2Rdy2", 0, {bus2.a_req_ready, bus2.b_req_ready}, 2'b10);
    step(); bus2.a_req_valid = 1'b0;
    chk("i2Addr2", 0, {s2Addr1, s2Addr2}, {4'd3, 4'd3});
    step(); step();
    chk("i2RspA", 0, {bus2.a_rsp_valid, bus2.b_rsp_valid, bus2.a_rsp_rdata}, 3'b101);

    // Instance 1 table.
    for (int i = 0; i < 12; i++) runVec(vecs[i], i);

    // Conflict: A writes 7=1, B reads 7; pointer at A.
    bus1.a_req_valid = 1'b1; bus1.a_req_we = 1'b1; bus1.a_req_addr = 4'd7; bus1.a_req_wdata = 1'b1;
    bus1.b_req_valid = 1'b1; bus1.b_req_we = 1'b0; bus1.b_req_addr = 4'd7; bus1.b_req_wdata = 1'b0;
    #1 chk("rawRdy1", 0, {bus1.a_req_ready, bus1.b_req_ready}, 2'b10);
    step(); bus1.a_req_valid = 1'b0;
    chk("rawPins1", 0, {s1Addr1, s1Addr2, s1Rdwr, s1Wdata}, {4'd7, 4'd7, 2'b11});
    step(); step();
    chk("rawRspA", 0, {bus1.a_rsp_valid, bus1.b_rsp_valid}, 2'b10);
    chk("rawRdy2", 0, {bus1.a_req_ready, bus1.b_req_ready}, 2'b01);
    step(); bus1.b_req_valid = 1'b0;
    chk("rawPins2", 0, {s1Addr1, s1Addr2, s1Rdwr}, {4'd7, 4'd7, 1'b0});
    step(); step();
    chk("rawRspB", 0, {bus1.a_rsp_valid, bus1.b_rsp_valid, bus1.b_rsp_rdata}, 3'b011);

    // Reset while an A read is in ACCESS (pointer is at B here).
    bus1.a_req_valid = 1'b1; bus1.a_req_we = 1'b0; bus1.a_req_addr = 4'd7;
    step(); bus1.a_req_valid = 1'b0;
    step();
    chk("preRstEn", 0, s1DevEnN, 1'b0);
    rst_n = 1'b0;
    for (int r = 0; r < 2; r++) begin
      step();
      chk("inRst", r, {s1DevEnN, s1Rdwr, s1Busy, bus1.a_rsp_valid, bus1.b_rsp_valid, s1Addr1}, {5'b10000, 4'd0});
    end
    rst_n = 1'b1;
    step();
    chk("postRst", 0, {s1DevEnN, s1Busy, bus1.a_rsp_valid}, 3'b100);

    // Continuous write contention after reset: grants alternate A,B,A,B.
    bus1.a_req_valid = 1'b1; bus1.a_req_we = 1'b1; bus1.a_req_addr = 4'd1; bus1.a_req_wdata = 1'b1;
    bus1.b_req_valid = 1'b1; bus1.b_req_we = 1'b1; bus1.b_req_addr = 4'd2; bus1.b_req_wdata = 1'b1;
    for (int g = 0; g < 4; g++) begin
      logic expA;
      expA = (g % 2 == 0);
      #1;
      chk("altRdy", g, {bus1.a_req_ready, bus1.b_req_ready}, {expA, !expA});
      step();
      chk("altAddr", g, s1Addr1, expA ? 4'd1 : 4'd2);
      step(); step();
      chk("altRsp", g, {bus1.a_rsp_valid, bus1.b_rsp_valid}, {expA, !expA});
    end
    bus1.a_req_valid = 1'b0; bus1.b_req_valid = 1'b0;

    // Read back B's write through A.
    bus1.a_req_valid = 1'b1; bus1.a_req_we = 1'b0; bus1.a_req_addr = 4'd2;
    #1 chk("rbRdy", 0, bus1.a_req_ready, 1'b1);
    step(); bus1.a_req_valid = 1'b0; step(); step();
    chk("rbRsp", 0, {bus1.a_rsp_valid, bus1.a_rsp_rdata}, 2'b11);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
